// File: rtl/vga_pixel_fetch_if.sv
// rtl/vga_pixel_fetch_if.sv - memory-side and display-side signals of the VGA pixel fetcher
//
// Purpose: groups the memory_interface VGA port (vga_flag / done_vga / vga_pixel)
// and the display pixel port (pix_req / pixel_out / pixel_valid).
// master: the pixel fetcher (drives vga_flag, pixel_out, pixel_valid).
// slave : the environment (memory_interface + VGA timing generator).
interface vga_pixel_fetch_if #(
    parameter int MEM_W = 36,
    parameter int PIX_W = 12
);
    logic             vga_flag;
    logic             done_vga;
    logic [MEM_W-1:0] vga_pixel;
    logic             pix_req;
    logic [PIX_W-1:0] pixel_out;
    logic             pixel_valid;

    modport master (
        output vga_flag, pixel_out, pixel_valid,
        input  done_vga, vga_pixel, pix_req
    );

    modport slave (
        input  vga_flag, pixel_out, pixel_valid,
        output done_vga, vga_pixel, pix_req
    );
endinterface

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - VGA word requester with word FIFO and pixel unpacker
//
// Purpose: requests sequential pixel words from memory_interface, buffers them in a
// DEPTH-word FIFO and hands out one PIX_W pixel per pix_req, lane 0 first.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   frame_start_i     - pulse at start of vertical blanking
//   bus (master)      - vga_flag/done_vga/vga_pixel, pix_req/pixel_out/pixel_valid
//   underflow_o       - sticky: pix_req with FIFO empty
//   overflow_o        - sticky: word arrived with FIFO full (and no pop)
//   frame_abort_o     - sticky: frame_start while still fetching
module vga_pixel_fetch #(
    parameter int MEM_W        = 36,
    parameter int PIX_W        = 12,
    parameter int PIX_PER_WORD = 3,
    parameter int DEPTH        = 16,
    parameter int SLACK        = 4,
    parameter int FRAME_WORDS  = 102400
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start_i,
    vga_pixel_fetch_if.master bus,
    output logic              underflow_o,
    output logic              overflow_o,
    output logic              frame_abort_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int RW = 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [MEM_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [RW-1:0]    words_rx_q, words_rx_d;
    logic             vga_flag_q, vga_flag_d;
    logic [PIX_W-1:0] pixel_out_q;
    logic             pixel_valid_q;
    logic             underflow_q, overflow_q, frame_abort_q;

    logic             in_fetch, abort, fifo_empty, fifo_full, last_lane, last_word;
    logic             pix_hit, pop, accept, push, drop;
    logic [MEM_W-1:0] head;
    logic [PIX_W-1:0] lane_pix;

    assign in_fetch   = (state_q == S_FETCH);
    assign abort      = in_fetch && frame_start_i;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign last_lane  = (lane_q == LW'(PIX_PER_WORD - 1));
    assign last_word  = (words_rx_q == RW'(FRAME_WORDS - 1));

    assign pix_hit = bus.pix_req && !fifo_empty;
    assign pop     = pix_hit && last_lane;
    // A frame_start in FETCH discards any coincident word.
    assign accept  = bus.done_vga && in_fetch && !frame_start_i;
    // A full FIFO still takes the word when the head is popped in the same cycle.
    assign push    = accept && (!fifo_full || pop);
    assign drop    = accept && fifo_full && !pop;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        lane_pix = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (lane_q == LW'(i)) begin
                lane_pix = head[i*PIX_W +: PIX_W];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start_i) state_d = S_FETCH;
            S_FETCH: if (accept && last_word) state_d = S_DONE;
            S_DONE:  if (frame_start_i) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        count_d    = count_q + CW'(push) - CW'(pop);
        lane_d     = lane_q;
        words_rx_d = words_rx_q;
        if (pix_hit) begin
            lane_d = last_lane ? '0 : lane_q + LW'(1);
        end
        if (abort) begin
            count_d = '0;
            lane_d  = '0;
        end
        if (frame_start_i) begin
            words_rx_d = '0;
        end else if (accept && !last_word) begin
            // Dropped words are still counted to stay aligned with the memory address.
            words_rx_d = words_rx_q + RW'(1);
        end
        // Keep SLACK words of room for requests already in flight.
        vga_flag_d = (state_d == S_FETCH) && ((CW'(DEPTH) - count_d) > CW'(SLACK));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            lane_q        <= '0;
            words_rx_q    <= '0;
            vga_flag_q    <= 1'b0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            lane_q        <= lane_d;
            words_rx_q    <= words_rx_d;
            vga_flag_q    <= vga_flag_d;
            pixel_valid_q <= bus.pix_req;
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (bus.pix_req) begin
                pixel_out_q <= fifo_empty ? '0 : lane_pix;
            end
            if (bus.pix_req && fifo_empty) underflow_q <= 1'b1;
            if (drop)                      overflow_q  <= 1'b1;
            if (abort)                     frame_abort_q <= 1'b1;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.vga_pixel;
        end
    end

    assign bus.vga_flag    = vga_flag_q;
    assign bus.pixel_out   = pixel_out_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign underflow_o     = underflow_q;
    assign overflow_o      = overflow_q;
    assign frame_abort_o   = frame_abort_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - self-checking bench for vga_pixel_fetch
module tb_vga_pixel_fetch;
    localparam int FW    = 600;
    localparam int DEPTH = 16;
    localparam int SLACK = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic frame_start_i = 1'b0;
    logic underflow_o, overflow_o, frame_abort_o;

    vga_pixel_fetch_if #(.MEM_W(36), .PIX_W(12)) bus ();

    vga_pixel_fetch #(.FRAME_WORDS(FW)) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_start_i (frame_start_i),
        .bus           (bus),
        .underflow_o   (underflow_o),
        .overflow_o    (overflow_o),
        .frame_abort_o (frame_abort_o)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: word queue, current lane, frame phase (0 idle, 1 fetching, 2 done)
    logic [35:0] mq[$];
    int          m_lane, m_words, m_phase;
    logic        exp_flag, exp_valid, exp_under, exp_over, exp_abort;
    logic [11:0] exp_pix;

    function automatic logic [35:0] rand_word();
        logic [35:0] w;
        w[31:0]  = $urandom;
        w[35:32] = 4'($urandom_range(0, 15));
        return w;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_lane = 0; m_words = 0; m_phase = 0;
        exp_flag = 0; exp_valid = 0; exp_under = 0; exp_over = 0; exp_abort = 0;
        exp_pix = '0;
    endfunction

    function automatic void model_edge(input logic fs, input logic pr, input logic dv, input logic [35:0] w);
        logic [35:0] h;
        exp_valid = pr;
        if (pr) begin
            if (mq.size() == 0) begin
                exp_pix   = '0;
                exp_under = 1'b1;
            end else begin
                h       = mq[0];
                exp_pix = h[m_lane*12 +: 12];
                m_lane++;
                if (m_lane == 3) begin
                    void'(mq.pop_front());
                    m_lane = 0;
                end
            end
        end
        if (fs) begin
            if (m_phase == 1) begin
                mq.delete();
                m_lane    = 0;
                exp_abort = 1'b1;
            end
            m_words = 0;
            m_phase = 1;
        end else if (dv && m_phase == 1) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else exp_over = 1'b1;
            if (m_words == FW - 1) m_phase = 2;
            else m_words++;
        end
        exp_flag = (m_phase == 1) && ((DEPTH - mq.size()) > SLACK);
    endfunction

    task automatic step(input logic fs, input logic pr, input logic dv, input logic [35:0] w);
        frame_start_i = fs;
        bus.pix_req   = pr;
        bus.done_vga  = dv;
        bus.vga_pixel = w;
        @(posedge clock);
        model_edge(fs, pr, dv, w);
        #1;
        frame_start_i = 1'b0;
        bus.pix_req   = 1'b0;
        bus.done_vga  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        frame_start_i = 1'b0;
        bus.pix_req = 1'b0;
        bus.done_vga = 1'b0;
        bus.vga_pixel = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 0, 0, '0);
        step(0, 1, 1, rand_word());
        step(0, 1, 0, '0);
        do_reset();
        checks++; if (bus.vga_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", bus.vga_flag); end
        checks++; if (bus.pixel_out !== 12'h000) begin errors++; $display("FAIL reset_pix: got %h want 000", bus.pixel_out); end
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.pixel_valid); end
        checks++; if ({underflow_o, overflow_o, frame_abort_o} !== 3'b000) begin
            errors++; $display("FAIL reset_sticky: got %b want 000", {underflow_o, overflow_o, frame_abort_o});
        end
    endtask

    // Memory answers 2 cycles after every vga_flag cycle; flag must track free space.
    task automatic test_fill();
        logic [2:0] fh;
        do_reset();
        step(1, 0, 0, '0);
        fh = {2'b00, bus.vga_flag};
        for (int c = 0; c < 40; c++) begin
            step(0, 0, fh[2], rand_word());
            fh = {fh[1:0], bus.vga_flag};
            checks++; if (bus.vga_flag !== exp_flag) begin
                errors++; $display("FAIL fill_flag c=%0d words=%0d: got %b want %b", c, mq.size(), bus.vga_flag, exp_flag);
            end
        end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fill_overflow: got %b want 0", overflow_o); end
    endtask

    task automatic test_unpack();
        logic [11:0] want [3];
        logic [35:0] w;
        want[0] = 12'h456; want[1] = 12'h123; want[2] = 12'hABC;
        do_reset();
        step(1, 0, 0, '0);
        step(0, 0, 1, 36'hABC_123_456);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, '0);
            checks++; if (bus.pixel_valid !== 1'b1 || bus.pixel_out !== want[i]) begin
                errors++; $display("FAIL unpack_lane%0d: got v=%b %h want v=1 %h", i, bus.pixel_valid, bus.pixel_out, want[i]);
            end
        end
        step(0, 0, 0, '0);
        checks++; if (bus.pixel_valid !== 1'b0 || bus.pixel_out !== 12'hABC) begin
            errors++; $display("FAIL unpack_hold: got v=%b %h want v=0 abc", bus.pixel_valid, bus.pixel_out);
        end
        // FIFO is now empty: underflow returns a zero pixel and keeps lane 0
        step(0, 1, 0, '0);
        checks++; if (bus.pixel_valid !== 1'b1 || bus.pixel_out !== 12'h000 || underflow_o !== 1'b1) begin
            errors++; $display("FAIL underflow: got v=%b %h u=%b want v=1 000 u=1", bus.pixel_valid, bus.pixel_out, underflow_o);
        end
        w = rand_word();
        step(0, 0, 1, w);
        step(0, 1, 0, '0);
        checks++; if (bus.pixel_out !== w[11:0]) begin
            errors++; $display("FAIL underflow_lane: got %h want %h", bus.pixel_out, w[11:0]);
        end
    endtask

    // Random traffic over two full frames; words_rx must restart on the second frame_start.
    task automatic test_frame();
        int cyc;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            step(1, 0, 0, '0);
            checks++; if (bus.vga_flag !== exp_flag) begin
                errors++; $display("FAIL frame%0d_start_flag: got %b want %b", f, bus.vga_flag, exp_flag);
            end
            cyc = 0;
            while (m_phase != 2 && cyc < 8000) begin
                step(0, ($urandom_range(0, 9) != 0), bus.vga_flag && ($urandom_range(0, 3) != 0), rand_word());
                cyc++;
                checks++; if (bus.vga_flag !== exp_flag || bus.pixel_valid !== exp_valid || bus.pixel_out !== exp_pix) begin
                    errors++; $display("FAIL frame%0d_cycle%0d: got f=%b v=%b p=%h want f=%b v=%b p=%h", f, cyc,
                        bus.vga_flag, bus.pixel_valid, bus.pixel_out, exp_flag, exp_valid, exp_pix);
                end
            end
            checks++; if (m_phase != 2) begin errors++; $display("FAIL frame%0d_budget: got phase %0d want 2", f, m_phase); end
            // In DONE: words ignored, flag low, remaining words drain
            for (int c = 0; c < 60; c++) begin
                step(0, 1, 1, rand_word());
                checks++; if (bus.vga_flag !== 1'b0 || bus.pixel_out !== exp_pix) begin
                    errors++; $display("FAIL frame%0d_done: got f=%b p=%h want f=0 p=%h", f, bus.vga_flag, bus.pixel_out, exp_pix);
                end
            end
        end
        checks++; if (overflow_o !== exp_over || frame_abort_o !== 1'b0) begin
            errors++; $display("FAIL frame_sticky: got o=%b a=%b want o=%b a=0", overflow_o, frame_abort_o, exp_over);
        end
    endtask

    task automatic test_abort();
        int cyc = 0;
        do_reset();
        step(1, 0, 0, '0);
        while (m_words < 500 && cyc < 8000) begin
            step(0, ($urandom_range(0, 9) != 0), bus.vga_flag && ($urandom_range(0, 3) != 0), rand_word());
            cyc++;
        end
        checks++; if (m_words != 500) begin errors++; $display("FAIL abort_budget: got %0d words want 500", m_words); end
        checks++; if (frame_abort_o !== 1'b0) begin errors++; $display("FAIL abort_pre: got %b want 0", frame_abort_o); end
        step(1, 0, 1, rand_word());
        checks++; if (frame_abort_o !== 1'b1 || bus.vga_flag !== exp_flag) begin
            errors++; $display("FAIL abort_flag: got a=%b f=%b want a=1 f=%b", frame_abort_o, bus.vga_flag, exp_flag);
        end
        step(0, 1, 0, '0);
        checks++; if (bus.pixel_out !== 12'h000 || underflow_o !== 1'b1) begin
            errors++; $display("FAIL abort_flushed: got p=%h u=%b want p=000 u=1", bus.pixel_out, underflow_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(1, 0, 0, '0);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 1, rand_word());
            checks++; if (overflow_o !== (i == 16)) begin
                errors++; $display("FAIL overflow_push%0d: got %b want %b", i, overflow_o, (i == 16));
            end
        end
        for (int i = 0; i < 49; i++) begin
            step(0, 1, 0, '0);
            checks++; if (bus.pixel_out !== exp_pix || underflow_o !== exp_under) begin
                errors++; $display("FAIL overflow_drain%0d: got p=%h u=%b want p=%h u=%b", i, bus.pixel_out, underflow_o, exp_pix, exp_under);
            end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        step(1, 0, 0, '0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, rand_word());
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        step(0, 1, 1, rand_word());
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL full_pop_overflow: got %b want 0", overflow_o); end
        step(0, 0, 1, rand_word());
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL full_nopop_overflow: got %b want 1", overflow_o); end
        for (int i = 0; i < 48; i++) begin
            step(0, 1, 0, '0);
            checks++; if (bus.pixel_out !== exp_pix || underflow_o !== exp_under) begin
                errors++; $display("FAIL full_pop_drain%0d: got p=%h u=%b want p=%h u=%b", i, bus.pixel_out, underflow_o, exp_pix, exp_under);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, rand_word());
        do_reset();
        checks++; if (bus.vga_flag !== 1'b0 || underflow_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got f=%b u=%b want 0 0", bus.vga_flag, underflow_o);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, rand_word());
        step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        checks++; if (bus.pixel_out !== 12'h000 || underflow_o !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ignored: got p=%h u=%b want 000 1", bus.pixel_out, underflow_o);
        end
    endtask

    initial begin
        bus.pix_req   = 1'b0;
        bus.done_vga  = 1'b0;
        bus.vga_pixel = '0;
        model_clear();
        test_reset();
        test_fill();
        test_unpack();
        test_frame();
        test_abort();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
